// File: rtl/seg7_pattern_reader.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pattern_reader
//  Purpose  : Samples a seven-segment pattern bus, waits for it to settle,
//             decodes it back to a hex digit and offers it on valid/ready.
//  Options  : SEG7_DP_CAPTURE_EN - include the decimal point in pattern
//             comparison and report it on digit_dp.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_pattern_reader #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_in,
  input  logic             dp_in,
  input  logic             digit_ready,
  input  logic             clr_overrun,
  output logic [3:0]       digit_out,
  output logic             digit_dp,
  output logic             digit_invalid,
  output logic             digit_valid,
  output logic             overrun,
  output logic [CNT_W-1:0] change_count
);

`ifdef SEG7_DP_CAPTURE_EN
  localparam int PW = 8;
  logic [PW-1:0] pad_pattern;
  assign pad_pattern = {dp_in, seg_in};
`else
  localparam int PW = 7;
  logic [PW-1:0] pad_pattern;
  logic          unused_dp;
  assign pad_pattern = seg_in;
  assign unused_dp   = dp_in;
`endif

  localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  logic [PW-1:0] sync_q1;
  logic [PW-1:0] sync_q2;
  logic [PW-1:0] cand;
  logic [PW-1:0] last_acc;
  logic [7:0]    cnt;
  logic          accept;
  logic          capture;
  logic          overrun_set;
  logic [4:0]    decoded;
  logic          dp_q;
  state_t        state;
  state_t        state_next;

  // Returns {invalid, digit}; unknown patterns decode to digit 0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'b1_0000;
    case (p)
      7'h3F: r = 5'h00;
      7'h06: r = 5'h01;
      7'h5B: r = 5'h02;
      7'h4F: r = 5'h03;
      7'h66: r = 5'h04;
      7'h6D: r = 5'h05;
      7'h7D: r = 5'h06;
      7'h07: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h6F: r = 5'h09;
      7'h77: r = 5'h0A;
      7'h7C: r = 5'h0B;
      7'h39: r = 5'h0C;
      7'h5E: r = 5'h0D;
      7'h79: r = 5'h0E;
      7'h71: r = 5'h0F;
      default: r = 5'b1_0000;
    endcase
    return r;
  endfunction

  // Accept fires exactly once per settled pattern: on the cnt step into
  // saturation. A blank (all-zero) pattern only re-arms last_acc so that the
  // same digit shown again after a blank is captured again.
  assign accept      = (sync_q2 == cand) && (cnt == STABLE_LAST);
  assign capture     = accept && (cand != last_acc) && (cand != '0);
  assign overrun_set = capture && (state == FULL) && !digit_ready;
  assign decoded     = decode(cand[6:0]);
  assign digit_valid = (state == FULL);

`ifdef SEG7_DP_CAPTURE_EN
  assign digit_dp = dp_q;
`else
  assign digit_dp = 1'b0;
`endif

  // Two-flop synchronizer on the pad pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= pad_pattern;
      sync_q2 <= sync_q1;
    end
  end

  // Settle tracking: restart on any change, otherwise count up to saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand     <= '0;
      cnt      <= '0;
      last_acc <= '0;
    end else begin
      if (sync_q2 != cand) begin
        cand <= sync_q2;
        cnt  <= '0;
      end else if (cnt != STABLE_MAX) begin
        cnt <= cnt + 8'd1;
      end
      if (accept && (cand != last_acc)) begin
        last_acc <= cand;
      end
    end
  end

  // Output data, capture counter and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_out     <= '0;
      digit_invalid <= 1'b0;
      dp_q          <= 1'b0;
      change_count  <= '0;
      overrun       <= 1'b0;
    end else begin
      if (capture) begin
        digit_out     <= decoded[3:0];
        digit_invalid <= decoded[4];
        dp_q          <= cand[PW-1];
        change_count  <= change_count + 1'b1;
      end
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  // Output-side state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a capture always fills; a handshake empties only if no
  // capture lands on the same edge.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY: begin
        if (capture) state_next = FULL;
      end
      FULL: begin
        if (capture)          state_next = FULL;
        else if (digit_ready) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/seg7_pattern_reader.md
Name: seg7_pattern_reader

Overview:
Receive-side counterpart of our seven-segment display drivers. Samples a 7-segment pattern bus from pads (another design's display output or a bench loopback) and waits for the pattern to settle. Decodes it back to a hex digit and presents it on a valid/ready handshake. Sits behind ui_in in the tile top, feeding a digit consumer (checker or uio_out mirror).

Parameters:
STABLE_CYCLES, 16, consecutive synchronized cycles a pattern must hold before acceptance (legal 2..255)
CNT_W, 8, width of change_count

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
seg_in  in  7  segment pattern, seg_in[0]=a .. seg_in[6]=g, active-high (common cathode)
dp_in  in  1  decimal point segment
digit_ready  in  1  consumer accepts digit this cycle when digit_valid=1
clr_overrun  in  1  synchronous clear of overrun
digit_out  out  4  decoded hex value
digit_dp  out  1  captured decimal point (see Optional Feature)
digit_invalid  out  1  captured pattern is not in the decode table
digit_valid  out  1  digit_out/digit_invalid/digit_dp hold a pending capture
overrun  out  1  sticky: a capture overwrote an unconsumed one
change_count  out  CNT_W  number of captures since reset, wraps at 2^CNT_W

Behaviour:
- Reset: all outputs 0. Internal state is also reset: sync flops 0, cand=0, cnt=0, last_acc=0 (blank).
- Input path: 2-flop synchronizer on {dp_in, seg_in} -> sync.
- Settle counter:
  - sync != cand: cand<=sync, cnt<=0.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
  - The accept event fires on the edge where cnt moves STABLE_CYCLES-1 -> STABLE_CYCLES. It fires once per settled pattern.
- Latency: a seg_in change sampled at edge 1 gives digit_valid=1 after edge STABLE_CYCLES+3.
- On accept, compare cand with last_acc:
  - Equal: no action.
  - Pattern 0x00 (blank): last_acc<=0x00, no capture. A repeated digit after a blank is therefore captured again.
  - Other new pattern: last_acc<=cand, capture.
- Capture:
  - digit_out from the decode table.
  - digit_invalid=1 with digit_out=0 if the pattern is not in the table.
  - digit_valid<=1; change_count+=1.
- Decode table (gfedcba):
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Handshake:
  - digit_valid=1 and digit_ready=1 at an edge -> digit_valid<=0, unless a capture happens on the same edge.
  - Outputs are stable while digit_valid=1 and no new capture occurs.
- Capture while digit_valid=1 and digit_ready=0: overwrite the data, keep digit_valid=1, set overrun<=1.
- Capture on the same edge as a handshake: the new data wins, digit_valid stays 1, no overrun.
- Overrun clearing:
  - clr_overrun=1 clears overrun.
  - If a set and a clear land on the same edge, set wins.
- FSM (output side): EMPTY (digit_valid=0) and FULL (digit_valid=1).
  - EMPTY -> FULL on capture.
  - FULL -> EMPTY on handshake without capture.
  - FULL -> FULL on capture, with overrun if not handshaking.
- Glitches shorter than STABLE_CYCLES after synchronization never produce a capture.
- rst_n assertion mid-settle or in FULL returns immediately to reset values. The pending digit is lost.

Optional Feature:
SEG7_DP_CAPTURE_EN
- Defined:
  - dp is part of cand/last_acc comparison; a dp-only change is a new pattern.
  - digit_dp reports the captured dp.
  - 0x00 with dp=1 is a valid capture with digit_invalid=1.
- Undefined:
  - dp_in is ignored (not synchronized) and digit_dp is tied 0.
  - Comparison uses seg_in only.

Test Plan:
1. STABLE_CYCLES=4, reset then hold seg_in=0x5B with digit_ready=0 -> digit_valid rises after the 7th edge; digit_out=2, digit_invalid=0, change_count=1.
2. 0x06 pulsed for 3 cycles between 0x00 -> no capture, change_count unchanged.
3. Hold 0x7C while digit_ready=0, then switch to 0x39 -> digit_out=C, overrun=1. Then clr_overrun=1 for 1 cycle -> overrun=0. Then digit_ready=1 -> digit_valid=0 next edge.
4. 0x4F settle, 0x00 settle, 0x4F settle (ready=1 throughout) -> two captures of digit 3, change_count=2.
5. Pattern 0x55 settles -> digit_invalid=1, digit_out=0. With SEG7_DP_CAPTURE_EN: 0x3F plus dp toggle -> second capture with digit_dp=1. Without the macro: no second capture.
6. rst_n low mid-settle and in FULL -> all outputs 0 asynchronously. After release, first settled pattern captures normally.
